// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fwd_pkg;

   // Default register address width (32 architectural registers)
   localparam int DEFAULT_REG_AW = 5;

   // Select value meaning "take the operand from the register file"
   localparam int FWD_SEL_RF = 0;

   // Width of one select field: values 0..num_fwd must be encodable
   function automatic int fwd_sel_w(input int num_fwd);
      return $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Priority match of one EX source register against all forwarding stages.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs every cycle.
module fwd_src_sel
   import fwd_pkg::*;
#(
   parameter int REG_AW  = DEFAULT_REG_AW,
   parameter int NUM_FWD = 2,
   parameter int SEL_W   = fwd_sel_w(NUM_FWD)
) (
   input  logic [REG_AW-1:0]         rs,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
   input  logic [NUM_FWD-1:0]        fwd_regwrite,
   output logic [SEL_W-1:0]          sel
);

   // Scan oldest to youngest so the youngest matching stage is written last and wins
   always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_regwrite[k] &&
             (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
             (fwd_rd[k*REG_AW +: REG_AW] == rs)) begin
            sel = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use stall for the integer pipeline; HAZARD_STATS_EN adds stall/forward counters.
// Latency: fwd_sel and stall are combinational; loads stay stall-visible for LD_LAT cycles after issue.
// Backpressure: stall holds PC and IF/ID and suppresses the tracker push of the held instruction.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW  = DEFAULT_REG_AW,
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int LD_LAT  = 1,
   localparam int SEL_W  = fwd_sel_w(NUM_FWD)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [NUM_SRC*REG_AW-1:0]  ex_rs,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
   input  logic                       issue_valid,
   input  logic                       issue_is_load,
   input  logic [REG_AW-1:0]          issue_rd,
   input  logic [NUM_FWD*REG_AW-1:0]  fwd_rd,
   input  logic [NUM_FWD-1:0]         fwd_regwrite,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       stall
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                fwd_cnt
`endif
);

   logic [NUM_SRC*SEL_W-1:0] sel_raw;

   logic [LD_LAT-1:0] slot_vld_d, slot_vld_q;
   logic [REG_AW-1:0] slot_rd_d [LD_LAT];
   logic [REG_AW-1:0] slot_rd_q [LD_LAT];
   logic              push_vld;
   logic              hit;

   // One priority selector per source operand of the EX instruction
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(
         .REG_AW  (REG_AW),
         .NUM_FWD (NUM_FWD),
         .SEL_W   (SEL_W)
      ) u_src_sel (
         .rs           (ex_rs[i*REG_AW +: REG_AW]),
         .fwd_rd       (fwd_rd),
         .fwd_regwrite (fwd_regwrite),
         .sel          (sel_raw[i*SEL_W +: SEL_W])
      );
   end

   // Reset forces all operands back to the register file
   assign fwd_sel = reset ? '0 : sel_raw;

   // Compare every tracked load against every ID source
   always_comb begin
      hit = 1'b0;
      for (int j = 0; j < LD_LAT; j++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (slot_vld_q[j] && (slot_rd_q[j] == id_rs[i*REG_AW +: REG_AW])) begin
               hit = 1'b1;
            end
         end
      end
   end

   // Flush wins over a dependency so the squashed ID instruction never holds the pipe
   assign stall = ~reset & id_valid & ~flush & hit;

   // Only a load that actually advances into EX (not held by stall) with a real rd is tracked
   always_comb begin
      push_vld = issue_valid & ~stall & issue_is_load & (issue_rd != '0);
   end

   // Shift the tracker every cycle; bubbles enter as invalid and flush empties it
   always_comb begin
      slot_vld_d    = '0;
      slot_rd_d[0]  = issue_rd;
      slot_vld_d[0] = push_vld;
      for (int j = 1; j < LD_LAT; j++) begin
         slot_vld_d[j] = slot_vld_q[j-1];
         slot_rd_d[j]  = slot_rd_q[j-1];
      end
      if (flush) begin
         slot_vld_d = '0;
      end
   end

   // Tracker state, cleared immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_vld_q <= '0;
         for (int j = 0; j < LD_LAT; j++) begin
            slot_rd_q[j] <= '0;
         end
      end else begin
         slot_vld_q <= slot_vld_d;
         for (int j = 0; j < LD_LAT; j++) begin
            slot_rd_q[j] <= slot_rd_d[j];
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] fwd_cnt_d,   fwd_cnt_q;

   // Free-running event counters; wrap naturally and survive flush
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      fwd_cnt_d   = fwd_cnt_q + {31'd0, (|fwd_sel)};
   end

   // Counter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding vector table plus load-use, flush and reset sequences.
// Two instances share stimulus: LD_LAT=1 (u_dut1) and LD_LAT=2 (u_dut2).
// HAZARD_STATS_EN also checks the counters.
module tb_fwd_hazard_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [9:0]  ex_rs;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic        issue_valid;
   logic        issue_is_load;
   logic [4:0]  issue_rd;
   logic [9:0]  fwd_rd;
   logic [1:0]  fwd_regwrite;
   logic [3:0]  fwd_sel1, fwd_sel2;
   logic        stall1, stall2;
`ifdef HAZARD_STATS_EN
   logic [31:0] scnt1, fcnt1, scnt2, fcnt2;
`endif

   int checks   = 0;
   int failures = 0;

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush), .ex_rs(ex_rs), .id_valid(id_valid),
      .id_rs(id_rs), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
      .issue_rd(issue_rd), .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite),
      .fwd_sel(fwd_sel1), .stall(stall1)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(scnt1), .fwd_cnt(fcnt1)
`endif
   );

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .flush(flush), .ex_rs(ex_rs), .id_valid(id_valid),
      .id_rs(id_rs), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
      .issue_rd(issue_rd), .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite),
      .fwd_sel(fwd_sel2), .stall(stall2)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(scnt2), .fwd_cnt(fcnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] rs0, rs1;
      logic [4:0] rd0, rd1;
      logic [1:0] we;
      logic [1:0] sel0, sel1;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 0; ex_rs = '0; id_valid = 0; id_rs = '0;
      issue_valid = 0; issue_is_load = 0; issue_rd = '0;
      fwd_rd = '0; fwd_regwrite = '0;
   endtask

   task automatic issue_load(input logic [4:0] rd);
      issue_valid = 1; issue_is_load = 1; issue_rd = rd;
   endtask

   initial begin
      //              rs0    rs1    rd0    rd1    we     sel0  sel1
      vecs[0] = '{5'd5,  5'd0,  5'd5,  5'd5,  2'b11, 2'd1, 2'd0}; // youngest wins
      vecs[1] = '{5'd0,  5'd7,  5'd0,  5'd7,  2'b11, 2'd0, 2'd2}; // x0 never forwards
      vecs[2] = '{5'd5,  5'd5,  5'd5,  5'd5,  2'b10, 2'd2, 2'd2}; // only MEM/WB writes
      vecs[3] = '{5'd9,  5'd9,  5'd9,  5'd9,  2'b00, 2'd0, 2'd0}; // no regwrite
      vecs[4] = '{5'd4,  5'd31, 5'd31, 5'd4,  2'b11, 2'd2, 2'd1}; // crossed sources
      vecs[5] = '{5'd13, 5'd12, 5'd12, 5'd13, 2'b01, 2'd0, 2'd1}; // MEM/WB disabled
      vecs[6] = '{5'd0,  5'd0,  5'd0,  5'd0,  2'b11, 2'd0, 2'd0}; // all x0

      // Reset state: forwarding match present but reset must force zeros
      clear_inputs();
      reset = 1;
      fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11; ex_rs = {5'd5, 5'd5};
      id_valid = 1;
      #3;
      chk("reset_fwd_sel1", 32'(fwd_sel1), 0);
      chk("reset_fwd_sel2", 32'(fwd_sel2), 0);
      chk("reset_stall1", 32'(stall1), 0);
`ifdef HAZARD_STATS_EN
      chk("reset_stall_cnt", scnt1, 0);
      chk("reset_fwd_cnt", fcnt1, 0);
`endif
      @(negedge clk);
      reset = 0;
      clear_inputs();
      tick();

      // Forwarding vector table
      for (int v = 0; v < 7; v++) begin
         ex_rs        = {vecs[v].rs1, vecs[v].rs0};
         fwd_rd       = {vecs[v].rd1, vecs[v].rd0};
         fwd_regwrite = vecs[v].we;
         #2;
         chk($sformatf("vec%0d_sel0", v), 32'(fwd_sel1[1:0]), 32'(vecs[v].sel0));
         chk($sformatf("vec%0d_sel1", v), 32'(fwd_sel1[3:2]), 32'(vecs[v].sel1));
      end
      clear_inputs();
      tick();

      // Load-use: one bubble at LD_LAT=1, two at LD_LAT=2
      issue_load(5'd3);
      tick();
      clear_inputs();
      id_valid = 1; id_rs = {5'd3, 5'd0};
      #1;
      chk("lu_c1_stall_lat1", 32'(stall1), 1);
      chk("lu_c1_stall_lat2", 32'(stall2), 1);
      tick();
      chk("lu_c2_stall_lat1", 32'(stall1), 0);
      chk("lu_c2_stall_lat2", 32'(stall2), 1);
      tick();
      chk("lu_c3_stall_lat1", 32'(stall1), 0);
      chk("lu_c3_stall_lat2", 32'(stall2), 0);
      clear_inputs();
      tick();

      // Stalled dependent load must not enter the tracker
      issue_load(5'd3);
      tick();
      id_valid = 1; id_rs = {5'd3, 5'd0};
      issue_load(5'd3);
      #1;
      chk("gate_c1_stall", 32'(stall1), 1);
      tick();
      chk("gate_c2_stall", 32'(stall1), 0);
      clear_inputs();
      tick(); tick(); tick();

      // Flush: kills tracked load and drops the same-cycle push
      issue_load(5'd3);
      tick();
      issue_load(5'd4);
      id_valid = 1; id_rs = {5'd3, 5'd4};
      flush = 1;
      #1;
      chk("flush_c1_stall_lat1", 32'(stall1), 0);
      chk("flush_c1_stall_lat2", 32'(stall2), 0);
      tick();
      flush = 0; issue_valid = 0; issue_is_load = 0;
      #1;
      chk("flush_c2_stall_lat1", 32'(stall1), 0);
      chk("flush_c2_stall_lat2", 32'(stall2), 0);
      clear_inputs();
      tick();

      // Asynchronous reset between edges with tracker occupied
      issue_load(5'd3);
      tick();
      clear_inputs();
      id_valid = 1; id_rs = {5'd3, 5'd0};
      fwd_rd = {5'd0, 5'd6}; fwd_regwrite = 2'b01; ex_rs = {5'd0, 5'd6};
      #1;
      chk("pre_rst_stall", 32'(stall1), 1);
      chk("pre_rst_fwd_sel", 32'(fwd_sel1), 1);
      #1;
      reset = 1;
      #1;
      chk("rst_stall_lat1", 32'(stall1), 0);
      chk("rst_stall_lat2", 32'(stall2), 0);
      chk("rst_fwd_sel_lat1", 32'(fwd_sel1), 0);
      chk("rst_fwd_sel_lat2", 32'(fwd_sel2), 0);
      #2;
      reset = 0;
      #1;
      chk("post_rst_stall_lat1", 32'(stall1), 0);
      chk("post_rst_stall_lat2", 32'(stall2), 0);
      tick();
      chk("post_rst_edge_stall_lat2", 32'(stall2), 0);
      clear_inputs();
      tick();

`ifdef HAZARD_STATS_EN
      // Counters from a clean reset: load-use sequence then four forwarding cycles
      reset = 1;
      #2;
      reset = 0;
      issue_load(5'd3);
      tick();
      clear_inputs();
      id_valid = 1; id_rs = {5'd3, 5'd0};
      tick();
      tick();
      clear_inputs();
      tick();
      chk("stats_stall_cnt_lat1", scnt1, 1);
      chk("stats_stall_cnt_lat2", scnt2, 2);
      chk("stats_fwd_cnt_idle", fcnt1, 0);
      fwd_rd = {5'd0, 5'd9}; fwd_regwrite = 2'b01; ex_rs = {5'd9, 5'd0};
      tick(); tick(); tick(); tick();
      clear_inputs();
      tick();
      chk("stats_fwd_cnt", fcnt1, 4);
      chk("stats_stall_cnt_hold", scnt1, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
